// File: rtl/gcr_serial_tx.sv
// GCR serial transmitter: one-entry holding register feeding a
// bit-timed MSB-first shifter that frames symbols behind sync bytes.
module gcr_serial_tx #(
    parameter int unsigned BIT_DIV  = 4,
    parameter int unsigned SYNC_LEN = 2,
    parameter logic [7:0]  SYNC_PAT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i,
    input  logic       i_valid,
    output logic       i_ready,
    output logic       o,
    output logic       busy,
    output logic       frame_end
);

    localparam logic [7:0] TMR_MAX   = 8'(BIT_DIV - 1);
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;

    logic [7:0] hold;
    logic       hold_full;
    logic       hold_full_n;

    logic [7:0] shifter;
    logic [7:0] shifter_n;
    logic [7:0] tmr;
    logic [7:0] tmr_n;
    logic [2:0] bitcnt;
    logic [2:0] bitcnt_n;
    logic [3:0] synccnt;
    logic [3:0] synccnt_n;

    logic       o_n;
    logic       busy_n;
    logic       frame_end_n;

    logic       accept;
    logic       bit_end;
    logic       byte_end;
    logic       sync_done;
    logic       load_hold;

    assign accept    = i_valid & i_ready;
    assign bit_end   = (tmr == TMR_MAX);
    assign byte_end  = bit_end && (bitcnt == 3'd7);
    assign sync_done = (synccnt == SYNC_LAST);

    // The held symbol moves into the shifter at the end of the last sync
    // byte, or back-to-back at the end of a data byte when one is waiting.
    assign load_hold = byte_end &&
                       (((state == SYNC) && sync_done) ||
                        ((state == DATA) && hold_full));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: a symbol waiting starts a frame; running dry ends it.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (hold_full) begin
                    state_n = SYNC;
                end
            end
            SYNC: begin
                if (byte_end && sync_done) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (byte_end && !hold_full) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Shifter, bit timer, bit counter and sync counter updates.
    always_comb begin
        shifter_n = shifter;
        tmr_n     = tmr;
        bitcnt_n  = bitcnt;
        synccnt_n = synccnt;
        unique case (state)
            IDLE: begin
                tmr_n     = 8'd0;
                bitcnt_n  = 3'd0;
                synccnt_n = 4'd0;
                shifter_n = hold_full ? SYNC_PAT : 8'h00;
            end
            SYNC, DATA: begin
                if (!bit_end) begin
                    tmr_n = tmr + 8'd1;
                end else begin
                    tmr_n    = 8'd0;
                    bitcnt_n = bitcnt + 3'd1;
                    if (!byte_end) begin
                        shifter_n = {shifter[6:0], 1'b0};
                    end else if (load_hold) begin
                        shifter_n = hold;
                        synccnt_n = 4'd0;
                    end else if (state == SYNC) begin
                        shifter_n = SYNC_PAT;
                        synccnt_n = synccnt + 4'd1;
                    end else begin
                        shifter_n = 8'h00;
                    end
                end
            end
            default: begin
                tmr_n     = 8'd0;
                bitcnt_n  = 3'd0;
                synccnt_n = 4'd0;
                shifter_n = 8'h00;
            end
        endcase
    end

    // Output and holding-register flag decode from the next state.
    always_comb begin
        busy_n      = (state_n != IDLE);
        o_n         = busy_n ? shifter_n[7] : 1'b0;
        frame_end_n = (state == DATA) && (state_n == IDLE);
        hold_full_n = hold_full;
        if (accept) begin
            hold_full_n = 1'b1;
        end else if (load_hold) begin
            hold_full_n = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter <= 8'h00;
            tmr     <= 8'd0;
            bitcnt  <= 3'd0;
            synccnt <= 4'd0;
        end else begin
            shifter <= shifter_n;
            tmr     <= tmr_n;
            bitcnt  <= bitcnt_n;
            synccnt <= synccnt_n;
        end
    end

    // Holding register captures on accept only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= 8'h00;
            hold_full <= 1'b0;
        end else begin
            if (accept) begin
                hold <= i;
            end
            hold_full <= hold_full_n;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o         <= 1'b0;
            busy      <= 1'b0;
            frame_end <= 1'b0;
            i_ready   <= 1'b0;
        end else begin
            o         <= o_n;
            busy      <= busy_n;
            frame_end <= frame_end_n;
            i_ready   <= ~hold_full_n;
        end
    end

endmodule

// File: tb/tb_gcr_serial_tx.sv
// Scoreboard bench for gcr_serial_tx: several parameterisations run in
// parallel, each line stream deserialised and compared to accepted symbols.
module tb_gcr_serial_tx;

    localparam int NCFG = 4;

    logic clk;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int gi, input string nm,
                       input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL g%0d %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     gi, nm, act, act, exp, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : gi
        localparam int BD = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
        localparam int SL = (g == 1 || g == 2) ? 2 : 1;
        localparam logic [7:0] SP = (g == 2) ? 8'h2D : 8'hFF;
        localparam int SYM = 8 * BD;

        logic       rst_n;
        logic [7:0] i;
        logic       i_valid;
        logic       i_ready;
        logic       o;
        logic       busy;
        logic       frame_end;

        logic [7:0] exp_q[$];
        int         acc_cyc[$];
        int         len_q[$];
        int         dcnt_q[$];
        int         frames = 0;
        int         fe_cnt = 0;

        gcr_serial_tx #(
            .BIT_DIV (BD),
            .SYNC_LEN(SL),
            .SYNC_PAT(SP)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .i        (i),
            .i_valid  (i_valid),
            .i_ready  (i_ready),
            .o        (o),
            .busy     (busy),
            .frame_end(frame_end)
        );

        // Accept monitor: a handshake seen at negedge completes at the next posedge.
        always @(negedge clk) begin
            if (rst_n === 1'b1 && i_valid && i_ready === 1'b1) begin
                exp_q.push_back(i);
                acc_cyc.push_back(cyc);
            end
        end

        // Line monitor: collect busy cycles, decode each frame when it ends.
        bit   bits[$];
        bit   pbusy = 1'b0;
        always @(negedge clk) begin : mon
            int L;
            int nb;
            int base;
            bit ok;
            logic [7:0] by;
            if (rst_n !== 1'b1) begin
                bits.delete();
                pbusy = 1'b0;
            end else begin
                if (frame_end === 1'b1) fe_cnt++;
                if (frame_end === 1'b1 || (pbusy && !busy)) begin
                    chk(g, "frame_end_at_busy_fall", int'(frame_end),
                        int'(pbusy && !busy));
                end
                if (pbusy && !busy) begin
                    chk(g, "o_low_after_frame", int'(o), 0);
                    L  = bits.size();
                    nb = L / SYM;
                    chk(g, "frame_len_whole_bytes", L % SYM, 0);
                    chk(g, "frame_has_data", int'(nb > SL), 1);
                    ok = 1'b1;
                    for (int k = 0; k < nb; k++) begin
                        by = 8'h00;
                        for (int j = 0; j < 8; j++) begin
                            base = (k * 8 + j) * BD;
                            for (int c = 1; c < BD; c++) begin
                                if (bits[base + c] != bits[base]) ok = 1'b0;
                            end
                            by = {by[6:0], bits[base]};
                        end
                        if (k < SL) begin
                            chk(g, "sync_byte", int'(by), int'(SP));
                        end else if (exp_q.size() == 0) begin
                            chk(g, "unexpected_data_byte", int'(by), -1);
                        end else begin
                            chk(g, "data_byte", int'(by), int'(exp_q.pop_front()));
                        end
                    end
                    chk(g, "bit_hold_cycles", int'(ok), 1);
                    len_q.push_back(L);
                    dcnt_q.push_back(nb - SL);
                    frames++;
                    bits.delete();
                end
                if (busy === 1'b1) bits.push_back(o);
                pbusy = (busy === 1'b1);
            end
        end

        task automatic send(input logic [7:0] b);
            int t;
            t = 0;
            i = b;
            i_valid = 1'b1;
            @(negedge clk);
            while (i_ready !== 1'b1 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            if (i_ready !== 1'b1) chk(g, "accept_timeout", 0, 1);
            @(posedge clk);
            #1;
        endtask

        task automatic wait_frames(input int n);
            int t;
            t = 0;
            while (frames < n && t < 20000) begin
                @(posedge clk);
                t++;
            end
            chk(g, "frames_seen", int'(frames >= n), 1);
            @(posedge clk);
            #1;
        endtask

        task automatic wait_idle();
            int t;
            t = 0;
            while ((busy || !i_ready || exp_q.size() != 0) && t < 20000) begin
                @(posedge clk);
                t++;
            end
            chk(g, "drained_idle", int'(exp_q.size()) + int'(busy), 0);
            @(posedge clk);
            #1;
        endtask

        initial begin : drv
            int f0;
            int fe0;
            int n0;
            int t;
            rst_n   = 1'b0;
            i_valid = 1'b0;
            i       = 8'h00;
            repeat (3) @(posedge clk);
            #1;
            chk(g, "rst_o", int'(o), 0);
            chk(g, "rst_busy", int'(busy), 0);
            chk(g, "rst_ready", int'(i_ready), 0);
            chk(g, "rst_frame_end", int'(frame_end), 0);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk(g, "ready_after_rst", int'(i_ready), 1);

            // Single symbol frame.
            f0 = frames;
            fe0 = fe_cnt;
            send(8'h96);
            i_valid = 1'b0;
            wait_frames(f0 + 1);
            chk(g, "single_data_cnt", dcnt_q[dcnt_q.size() - 1], 1);
            chk(g, "single_busy_len", len_q[len_q.size() - 1], (SL + 1) * SYM);
            chk(g, "single_fe_cnt", fe_cnt - fe0, 1);

            // Streamed burst with back-pressure.
            f0 = frames;
            fe0 = fe_cnt;
            n0 = acc_cyc.size();
            send(8'hA6);
            chk(g, "ready_low_after_accept", int'(i_ready), 0);
            send(8'hB5);
            send(8'hFF);
            i_valid = 1'b0;
            wait_frames(f0 + 1);
            chk(g, "burst_data_cnt", dcnt_q[dcnt_q.size() - 1], 3);
            chk(g, "burst_busy_len", len_q[len_q.size() - 1], (SL + 3) * SYM);
            chk(g, "burst_fe_cnt", fe_cnt - fe0, 1);
            chk(g, "accepts_per_symbol", acc_cyc[n0 + 2] - acc_cyc[n0 + 1], SYM);
            wait_idle();

            // Symbol offered exactly on the frame-ending edge.
            f0 = frames;
            fe0 = fe_cnt;
            send(8'h3C);
            i_valid = 1'b0;
            t = 0;
            do begin
                @(posedge clk);
                #1;
                t++;
            end while (!busy && t < 100);
            repeat ((SL + 1) * SYM - 1) @(posedge clk);
            #1;
            i = 8'hC3;
            i_valid = 1'b1;
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            chk(g, "late_sym_frame_end", int'(frame_end), 1);
            chk(g, "late_sym_ready_low", int'(i_ready), 0);
            wait_frames(f0 + 2);
            chk(g, "late_sym_fe_cnt", fe_cnt - fe0, 2);
            chk(g, "late_sym_data_cnt", dcnt_q[dcnt_q.size() - 1], 1);
            wait_idle();

            // Reset in the middle of a data byte.
            f0 = frames;
            fe0 = fe_cnt;
            send(8'h71);
            i = 8'h8E;
            t = 0;
            while (!busy && t < 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            repeat (SL * SYM + 3 * BD) @(posedge clk);
            #1;
            i_valid = 1'b0;
            rst_n = 1'b0;
            exp_q.delete();
            #1;
            chk(g, "midrst_o", int'(o), 0);
            chk(g, "midrst_busy", int'(busy), 0);
            chk(g, "midrst_ready", int'(i_ready), 0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk(g, "midrst_ready_after", int'(i_ready), 1);
            chk(g, "midrst_no_fe", fe_cnt - fe0, 0);
            send(8'h5A);
            i_valid = 1'b0;
            wait_frames(f0 + 1);
            chk(g, "post_rst_data_cnt", dcnt_q[dcnt_q.size() - 1], 1);
            chk(g, "post_rst_fe_cnt", fe_cnt - fe0, 1);

            // Random traffic with random gaps.
            for (int k = 0; k < 30; k++) begin
                send(8'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    i_valid = 1'b0;
                    repeat ($urandom_range(1, 12 * BD)) @(posedge clk);
                    #1;
                end
            end
            i_valid = 1'b0;
            wait_idle();
            n_done++;
        end
    end

    initial begin : fin
        int t;
        t = 0;
        while (n_done < NCFG && t < 90000) begin
            @(posedge clk);
            t++;
        end
        if (n_done < NCFG) begin
            n_cmp++;
            n_bad++;
            $display("FAIL global_timeout: done %0d required %0d", n_done, NCFG);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcr_serial_tx.md
GCR_SERIAL_TX -- requirements
Module: gcr_serial_tx

Interface
REQ-001 SHALL have parameter BIT_DIV, default 4, meaning clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have parameter SYNC_LEN, default 2, meaning number of sync bytes sent before the first symbol of a frame (legal range 1..15).
REQ-003 SHALL have parameter SYNC_PAT, default 8'hFF, meaning the 8-bit sync byte pattern.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i, input, 8 bits: the GCR-encoded symbol from the upstream 6b-to-8b encoder stage.
REQ-007 SHALL have port i_valid, input, 1 bit: i holds a symbol to transmit.
REQ-008 SHALL have port i_ready, output, 1 bit, registered: the holding register is empty.
REQ-009 SHALL have port o, output, 1 bit, registered: the serial line, MSB first.
REQ-010 SHALL have port busy, output, 1 bit, registered: high in states SYNC and DATA.
REQ-011 SHALL have port frame_end, output, 1 bit, registered: one-cycle pulse when a frame finishes.

Function
REQ-012 SHALL accept a symbol on a clk edge where i_valid=1 and i_ready=1, capturing i into a one-entry holding register and setting hold_full.
REQ-013 SHALL drive i_ready as ~hold_full of the next state, so it is low the cycle after an accept and high again the cycle after the shifter takes the held symbol.
REQ-014 SHALL ignore i and i_valid while i_ready=0; no symbol is dropped or duplicated.
REQ-015 SHALL implement states IDLE, SYNC and DATA.
REQ-016 SHALL, in IDLE, hold o=0 and busy=0.
REQ-017 SHALL leave IDLE for SYNC on the first edge at which hold_full=1, loading SYNC_PAT into the shifter, so its MSB appears on o one cycle later.
REQ-018 SHALL hold every transmitted bit on o for exactly BIT_DIV cycles, using a bit-timer that counts 0..BIT_DIV-1, and send 8 bits per byte MSB first, with no gap between bytes.
REQ-019 SHALL, in SYNC, send exactly SYNC_LEN copies of SYNC_PAT, counted by a sync counter.
REQ-020 SHALL, after the last sync bit, enter DATA, load the held symbol into the shifter and clear hold_full in the same cycle.
REQ-021 SHALL, at the end of each symbol's last bit in DATA, load the held symbol back-to-back and stay in DATA if hold_full=1.
REQ-022 SHALL, at that point with hold_full=0, go to IDLE, drive o=0 and pulse frame_end for one cycle.
REQ-023 SHALL treat a symbol accepted in the same cycle the last bit ends as not yet held; the frame ends, and that symbol starts a new frame with fresh sync.
REQ-024 SHALL, with BIT_DIV=1, emit one bit per cycle with no idle cycles between bytes.
REQ-025 SHALL hold one symbol duration at BIT_DIV*8 cycles, always at least 8, so a single holding register sustains full line rate when i_valid is kept high.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force: state=IDLE, o=0, busy=0, frame_end=0, i_ready=0, hold_full=0, and all counters and the shifter to 0.
REQ-027 SHALL raise i_ready on the first clk edge after rst_n deasserts.
REQ-028 SHALL make a reset mid-frame abort transmission immediately and discard any held symbol; no frame_end pulse is produced.

Verification
REQ-029 SHALL cover, with BIT_DIV=2, SYNC_LEN=1 and a single symbol 8'h96: o = 11111111 then 10010110, each bit 2 cycles, then o=0, plus frame_end one cycle and busy high for exactly 32 cycles.
REQ-030 SHALL cover, with BIT_DIV=1, SYNC_LEN=2 and i_valid held high with 8'hA6, 8'hB5, 8'hFF: 16 sync bits, then 24 data bits contiguous with no gap, and a single frame_end.
REQ-031 SHALL cover back-pressure: i_valid held high during SYNC gives i_ready=0 after the first accept, and exactly one symbol is accepted per symbol period thereafter.
REQ-032 SHALL cover a symbol presented exactly at the frame_end cycle: a second frame with full sync follows, and two frame_end pulses occur in total.
REQ-033 SHALL cover rst_n pulsed low mid-DATA with BIT_DIV=4: o=0, busy=0 and i_ready=0 at once; i_ready=1 one edge after release; the next symbol starts with sync.
REQ-034 SHALL cover random stimulus over BIT_DIV in {1,3,4}: the deserialised o stream equals the accepted symbols in order, each frame preceded by SYNC_LEN sync bytes.
